// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM states,
// forward-select codes and RV32I opcodes.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: stage control bits in,
// stall/flush/forward/perf signals out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) ();

  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] ex_rs1_i;
  logic [REG_AW-1:0] ex_rs2_i;
  logic [REG_AW-1:0] ex_rd_i;
  logic              ex_reg_write_i;
  logic              ex_mem_read_i;
  logic              ex_redirect_i;
  logic [REG_AW-1:0] mem_rd_i;
  logic              mem_reg_write_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic              wb_reg_write_i;
  logic              dmem_req_i;
  logic              dmem_ready_i;

  logic              pc_stall_o;
  logic              ifid_stall_o;
  logic              idex_stall_o;
  logic              exmem_stall_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              memwb_bubble_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic              err_timeout_o;

  modport master (
    output id_rs1_i, id_rs2_i,
    output id_use_rs1_i, id_use_rs2_i,
    output ex_rs1_i, ex_rs2_i, ex_rd_i,
    output ex_reg_write_i, ex_mem_read_i,
    output ex_redirect_i,
    output mem_rd_i, mem_reg_write_i,
    output wb_rd_i, wb_reg_write_i,
    output dmem_req_i, dmem_ready_i,
    input  pc_stall_o, ifid_stall_o,
    input  idex_stall_o, exmem_stall_o,
    input  ifid_flush_o, idex_flush_o,
    input  memwb_bubble_o,
    input  fwd_a_o, fwd_b_o,
    input  stall_cnt_o, flush_cnt_o,
    input  err_timeout_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i,
    input  id_use_rs1_i, id_use_rs2_i,
    input  ex_rs1_i, ex_rs2_i, ex_rd_i,
    input  ex_reg_write_i, ex_mem_read_i,
    input  ex_redirect_i,
    input  mem_rd_i, mem_reg_write_i,
    input  wb_rd_i, wb_reg_write_i,
    input  dmem_req_i, dmem_ready_i,
    output pc_stall_o, ifid_stall_o,
    output idex_stall_o, exmem_stall_o,
    output ifid_flush_o, idex_flush_o,
    output memwb_bubble_o,
    output fwd_a_o, fwd_b_o,
    output stall_cnt_o, flush_cnt_o,
    output err_timeout_o
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forward select: ex_rs vs MEM/WB rd.
// MEM wins over WB; x0 is never forwarded.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);

  logic rs_nz;
  logic mem_hit;
  logic wb_hit;

  assign rs_nz   = |ex_rs;
  assign mem_hit = rs_nz & mem_we
                 & (mem_rd == ex_rs);
  assign wb_hit  = rs_nz & wb_we
                 & (wb_rd == ex_rs);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock,
// EX redirect flush, dmem wait, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input logic         clk_i,
  input logic         reset_i,
  hazard_ctrl_if.slave hz
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] W_MAX  = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] W_LAST = WCW'(MAX_WAIT - 1);

  hz_state_t        state;
  logic [WCW-1:0]   wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             err;

  logic mem_stall;
  logic redirect;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic redir_act;

  logic pc_stall;
  logic ifid_stall;
  logic idex_stall;
  logic exmem_stall;
  logic ifid_flush;
  logic idex_flush;
  logic bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign mem_stall = hz.dmem_req_i
                   & ~hz.dmem_ready_i;
  assign redirect  = hz.ex_redirect_i;
  assign rs1_hit   = hz.id_use_rs1_i
                   & (hz.id_rs1_i == hz.ex_rd_i);
  assign rs2_hit   = hz.id_use_rs2_i
                   & (hz.id_rs2_i == hz.ex_rd_i);
  assign load_use  = hz.ex_mem_read_i
                   & hz.ex_reg_write_i
                   & (|hz.ex_rd_i)
                   & (rs1_hit | rs2_hit);
  // A redirect only counts when the pipe is not
  // frozen by memory; a held EX re-resolves later.
  assign redir_act = reset_i & ~mem_stall
                   & redirect;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    bubble      = 1'b0;
    priority case (1'b1)
      ~reset_i: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        bubble     = 1'b1;
      end
      mem_stall: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        bubble      = 1'b1;
      end
      redirect: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      load_use: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs  (hz.ex_rs1_i),
    .mem_rd (hz.mem_rd_i),
    .mem_we (hz.mem_reg_write_i),
    .wb_rd  (hz.wb_rd_i),
    .wb_we  (hz.wb_reg_write_i),
    .sel    (fwd_a)
  );

  hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs  (hz.ex_rs2_i),
    .mem_rd (hz.mem_rd_i),
    .mem_we (hz.mem_reg_write_i),
    .wb_rd  (hz.wb_rd_i),
    .wb_we  (hz.wb_reg_write_i),
    .sel    (fwd_b)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN:
          if (mem_stall) state <= ST_MEM_WAIT;
        ST_MEM_WAIT:
          if (hz.dmem_ready_i) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
      if (mem_stall) begin
        if (wait_cnt != W_MAX)
          wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= W_LAST)
          err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      stall_cnt <= stall_cnt + CNT_W'(pc_stall);
      flush_cnt <= flush_cnt + CNT_W'(redir_act);
    end
  end

  assign hz.pc_stall_o     = pc_stall;
  assign hz.ifid_stall_o   = ifid_stall;
  assign hz.idex_stall_o   = idex_stall;
  assign hz.exmem_stall_o  = exmem_stall;
  assign hz.ifid_flush_o   = ifid_flush;
  assign hz.idex_flush_o   = idex_flush;
  assign hz.memwb_bubble_o = bubble;
  assign hz.fwd_a_o        = reset_i ? fwd_a : FWD_RF;
  assign hz.fwd_b_o        = reset_i ? fwd_b : FWD_RF;
  assign hz.stall_cnt_o    = stall_cnt;
  assign hz.flush_cnt_o    = flush_cnt;
  assign hz.err_timeout_o  = err;

endmodule
